// File: rtl/slave_out_port_pkg.sv
// Shared bus definitions for the slave read-response transmitter.
package slave_out_port_pkg;

  localparam int DATA_LEN_DEF = 8;

  localparam logic [1:0] READ_INSTR = 2'b11;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    WAIT_HANDSHAKE = 3'd1,
    SEND           = 3'd2,
    DONE           = 3'd3
  } port_state_e;

endpackage

// File: rtl/slave_out_port_tx_shift_reg.sv
// Parallel-in / serial-out register; presents the current LSB and shifts right
// with zero fill.
module tx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] shift_r;

  // Load has priority over shift; both are held off by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= '0;
    end else if (load) begin
      shift_r <= din;
    end else if (shift_en) begin
      shift_r <= {1'b0, shift_r[WIDTH-1:1]};
    end else begin
      shift_r <= shift_r;
    end
  end

  assign lsb = shift_r[0];

endmodule

// File: rtl/slave_out_port.sv
// Slave-side serial transmitter: latches a read word, handshakes with the
// master, then sends it LSB first, one bit per cycle.
module slave_out_port
  import slave_out_port_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_en,
  input  logic [DATA_LEN-1:0] data,
  input  logic                data_load,
  input  logic                master_ready,
  output logic                tx_data,
  output logic                slave_valid,
  output logic                tx_done,
  output logic                busy
);

  localparam int CNT_W = $clog2(DATA_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LEN - 1);

  port_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             tx_data_r;
  logic             slave_valid_r;
  logic             tx_done_r;
  logic             busy_r;
  logic             load_s;
  logic             shift_s;
  logic             lsb_s;

  // Shift register control: the handshake edge pops bit 0, each SEND edge pops the next.
  always_comb begin
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      IDLE:           load_s  = read_en & data_load;
      WAIT_HANDSHAKE: shift_s = read_en & master_ready;
      SEND:           shift_s = 1'b1;
      default: begin
        load_s  = 1'b0;
        shift_s = 1'b0;
      end
    endcase
  end

  tx_shift_reg #(
    .WIDTH (DATA_LEN)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .shift_en (shift_s),
    .din      (data),
    .lsb      (lsb_s)
  );

  // Frame FSM with bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      tx_data_r     <= 1'b0;
      slave_valid_r <= 1'b0;
      tx_done_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tx_done_r <= 1'b0;
          tx_data_r <= 1'b0;
          if (read_en && data_load) begin
            state_r       <= WAIT_HANDSHAKE;
            slave_valid_r <= 1'b1;
            busy_r        <= 1'b1;
          end else begin
            slave_valid_r <= 1'b0;
            busy_r        <= 1'b0;
          end
        end
        WAIT_HANDSHAKE: begin
          // A dropped read_en wins over a simultaneous master_ready.
          if (!read_en) begin
            state_r       <= IDLE;
            slave_valid_r <= 1'b0;
            busy_r        <= 1'b0;
          end else if (slave_valid_r && master_ready) begin
            state_r       <= SEND;
            slave_valid_r <= 1'b0;
            tx_data_r     <= lsb_s;
            cnt_r         <= '0;
          end else begin
            state_r <= WAIT_HANDSHAKE;
          end
        end
        SEND: begin
          if (cnt_r == LAST_BIT) begin
            state_r   <= DONE;
            tx_data_r <= 1'b0;
            tx_done_r <= 1'b1;
            cnt_r     <= '0;
          end else begin
            tx_data_r <= lsb_s;
            cnt_r     <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_r   <= IDLE;
          tx_done_r <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          cnt_r         <= '0;
          tx_data_r     <= 1'b0;
          slave_valid_r <= 1'b0;
          tx_done_r     <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data     = tx_data_r;
  assign slave_valid = slave_valid_r;
  assign tx_done     = tx_done_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_slave_out_port.sv
// Directed bench for slave_out_port with hand-computed bit sequences.
module tb_slave_out_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_en;
  logic [7:0] data;
  logic       data_load;
  logic       master_ready;
  logic       tx_data;
  logic       slave_valid;
  logic       tx_done;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  slave_out_port #(.DATA_LEN(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .read_en      (read_en),
    .data         (data),
    .data_load    (data_load),
    .master_ready (master_ready),
    .tx_data      (tx_data),
    .slave_valid  (slave_valid),
    .tx_done      (tx_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check(tag, {28'd0, tx_data, slave_valid, tx_done, busy}, 32'd0);
  endtask

  // Present a word in cycle L; returns in cycle L+1 after checking the load.
  task automatic load_word(input logic [7:0] w, input logic mr);
    read_en      = 1'b1;
    data         = w;
    data_load    = 1'b1;
    master_ready = mr;
    tick();
    data_load = 1'b0;
    check("load_valid", {31'd0, slave_valid}, 32'd1);
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_tx", {31'd0, tx_data}, 32'd0);
  endtask

  // Called in cycle H+1; checks all bits, the done pulse and the return to idle.
  task automatic expect_frame(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bit%0d", i), {31'd0, tx_data}, {31'd0, w[i]});
      check($sformatf("valid_low%0d", i), {31'd0, slave_valid}, 32'd0);
      check($sformatf("busy%0d", i), {31'd0, busy}, 32'd1);
      check($sformatf("no_done%0d", i), {31'd0, tx_done}, 32'd0);
      tick();
    end
    check("done_pulse", {31'd0, tx_done}, 32'd1);
    check("done_tx", {31'd0, tx_data}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd1);
    tick();
    check("after_done", {31'd0, tx_done}, 32'd0);
    check("after_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    read_en      = 1'b0;
    data         = 8'h00;
    data_load    = 1'b0;
    master_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset_state");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("idle");
    end

    // data_load without read_en is ignored
    data      = 8'h5A;
    data_load = 1'b1;
    tick();
    data_load = 1'b0;
    check_idle("load_no_read_en");
    tick();
    check_idle("load_no_read_en2");

    // 8'hA5 with master_ready already high: cycle L+1 is the handshake cycle
    load_word(8'hA5, 1'b1);
    tick();
    expect_frame(8'hA5);

    // 8'h3C held in WAIT_HANDSHAKE for 6 cycles
    load_word(8'h3C, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("wait_valid", {31'd0, slave_valid}, 32'd1);
      check("wait_tx", {31'd0, tx_data}, 32'd0);
    end
    master_ready = 1'b1;
    tick();
    expect_frame(8'h3C);

    // 8'hFF aborted by dropping read_en
    load_word(8'hFF, 1'b0);
    read_en = 1'b0;
    tick();
    check_idle("abort");
    master_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_idle("abort_idle");
    end

    // reset in the middle of 8'h81 after three bits
    load_word(8'h81, 1'b1);
    tick();
    check("r_bit0", {31'd0, tx_data}, 32'd1);
    tick();
    check("r_bit1", {31'd0, tx_data}, 32'd0);
    tick();
    check("r_bit2", {31'd0, tx_data}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_send_reset");
    tick();
    check_idle("post_reset_idle");
    load_word(8'h01, 1'b1);
    tick();
    expect_frame(8'h01);

    // 8'hF0 with a competing load of 8'h00 held through the frame
    load_word(8'hF0, 1'b1);
    tick();
    data      = 8'h00;
    data_load = 1'b1;
    expect_frame(8'hF0);
    data_load    = 1'b0;
    master_ready = 1'b0;
    tick();
    check_idle("no_queued_load");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slave_out_port.md
# slave_out_port

Slave-side serial transmitter for bus read responses. Latches a parallel read word from slave memory, raises `slave_valid`, waits for the master's `master_ready`, then shifts the word out LSB-first, one bit per cycle, on `tx_data`. Sits directly upstream of the master input port. Its bit timing is defined so that the master captures bit 0 in the first cycle after the handshake.

## Interface
Parameters:
- `DATA_LEN`, 8, read word width in bits (≥2)

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising `clk`
- `read_en`  in  1  bus read enable from the master side; arms the port
- `data`  in  DATA_LEN  parallel read word from slave memory
- `data_load`  in  1  one-cycle strobe: `data` is valid this cycle
- `master_ready`  in  1  master able to receive (handshake partner of `slave_valid`)
- `tx_data`  out  1  serial read data, LSB first
- `slave_valid`  out  1  word loaded, waiting for handshake
- `tx_done`  out  1  one-cycle pulse after the last bit is driven
- `busy`  out  1  high from load until `tx_done` inclusive

## Operation
- All outputs are registered.
- Reset values: `tx_data`=0, `slave_valid`=0, `tx_done`=0, `busy`=0, state=IDLE, bit count=0, shift register=0.
- State machine:
  - IDLE:
    - If `read_en`=1 and `data_load`=1: shift register <= `data`, go to WAIT_HANDSHAKE.
    - `data_load` without `read_en` is ignored.
  - WAIT_HANDSHAKE:
    - `slave_valid`=1, `busy`=1.
    - If `slave_valid`=1 and `master_ready`=1 on the same edge: `tx_data` <= shift[0], shift right, count <= 0, go to SEND.
    - If `read_en` drops before the handshake: abort to IDLE, with `slave_valid`=0 next cycle and no `tx_done`.
  - SEND:
    - `slave_valid`=0.
    - Each cycle: `tx_data` <= next bit, count <= count+1.
    - After bit DATA_LEN-1 has been driven for one cycle: `tx_data` <= 0, go to DONE.
    - `read_en`, `master_ready` and `data_load` are ignored until the frame completes.
  - DONE:
    - `tx_done`=1 for exactly one cycle, `busy`=1, then IDLE.
- Bit counter width is $clog2(DATA_LEN). It saturates/clears at DATA_LEN-1 and never wraps mid-frame.
- `data_load` while `busy`=1 is dropped. There is no queueing.
- Reset asserted at any state (including mid-SEND) returns all outputs to reset values on that edge. A partial frame is abandoned.

## Timing
- Cycle L: `data_load`=`read_en`=1 in IDLE. Cycle L+1: `slave_valid`=1, `busy`=1.
- Handshake edge at end of cycle H (`slave_valid` & `master_ready`). Cycles H+1 … H+DATA_LEN: `tx_data` = bit 0 … bit DATA_LEN-1.
- `slave_valid` low from H+1.
- Cycle H+DATA_LEN+1: `tx_done`=1, `tx_data`=0.
- Cycle H+DATA_LEN+2: IDLE, `busy`=0, and a new load is accepted.
- Minimum load-to-first-bit latency: 2 cycles (`master_ready` already high at L+1).
- Back-to-back frames: next load no earlier than H+DATA_LEN+2.

## Structure
- Shared bus package holds:
  - `DATA_LEN` default
  - state encoding constants IDLE=0, WAIT_HANDSHAKE=1, SEND=2, DONE=3 (3-bit state, matching the bus port convention)
  - read instruction code 2'b11
- Sub-module: `tx_shift_reg`, a parallel-in/serial-out register (load, shift enable, LSB out).
- FSM and counter live in `slave_out_port`.

## Test plan
- Reset, then idle 5 cycles: all outputs 0; `data_load` with `read_en`=0 leaves `slave_valid`=0.
- Load `data`=8'hA5, `master_ready`=1:
  - `slave_valid` high for 1 cycle.
  - `tx_data` sequence 1,0,1,0,0,1,0,1 on cycles H+1..H+8.
  - `tx_done` at H+9, `busy` low at H+10.
- Load 8'h3C, hold `master_ready`=0 for 6 cycles: `slave_valid` stays high, `tx_data`=0. Raise `master_ready`: bits 0,0,1,1,1,1,0,0 follow.
- Load 8'hFF, drop `read_en` during WAIT_HANDSHAKE: `slave_valid`=0 next cycle, no `tx_done`, returns to IDLE.
- Mid-SEND (after 3 bits of 8'h81), assert `reset` for 1 cycle: all outputs 0 the next cycle. A fresh load of 8'h01 then transmits correctly.
- Second `data_load` of 8'h00 during SEND of 8'hF0: ignored, and 8'hF0 is transmitted intact.
